irrigation_actuator_fsm: RTL and testbench

Moore state machine that consumes the 3-bit tank level count from the water level controller and drives the irrigation actuators: tank inlet valve, sprinkler and dripper. It refills the tank between low and high thresholds, irrigates while the soil sensor reports dry, and latches a fault when a refill fails to complete within a tick budget. The `dripper` output also feeds the water level clock controller, which selects its halved level clock when drip irrigation is active.

---
 rtl/irrigation_pkg.sv | 17 +
 rtl/irrigation_tick_timer.sv | 23 ++
 rtl/irrigation_actuator_fsm.sv | 110 +++++++++++
 tb/tb_irrigation_actuator_fsm.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation actuator block and the water level controller.
// Holds the state encoding, the irrigation mode values and the tank level width.
package irrigation_pkg;

  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    IRRIGATE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic MODE_SPRINKLER = 1'b0;
  localparam logic MODE_DRIP      = 1'b1;

endpackage

// File: rtl/irrigation_tick_timer.sv
// Tick-enabled saturating up-counter: synchronous clear has priority over counting.
// Count updates 1 cycle after the tick; there is no backpressure, and the count holds at all-ones.
module irrigation_tick_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/irrigation_actuator_fsm.sv
// Moore FSM driving the tank inlet valve, sprinkler and dripper. Outputs settle 1 cycle after inputs; there is no backpressure.
// Defining IRRIGATION_MIN_ON_EN holds IRRIGATE for at least MIN_ON ticks before a dry-soil exit is taken.
module irrigation_actuator_fsm
  import irrigation_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] LEVEL_LOW    = 3'd1,
  parameter logic [LEVEL_W-1:0] LEVEL_HIGH   = 3'd6,
  parameter int                 TIMER_W      = 8,
  parameter int                 FILL_TIMEOUT = 200
`ifdef IRRIGATION_MIN_ON_EN
  ,
  parameter int                 MIN_ON       = 10
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soil_dry,
  input  logic               mode_drip,
  input  logic               tick,
  input  logic               fault_ack,
  output logic               valve_in,
  output logic               sprinkler,
  output logic               dripper,
  output logic               alarm,
  output logic [1:0]         state_out
);

  state_t               state, state_nxt;
  logic                 mode_q, mode_nxt;
  logic                 timer_clr, timer_en;
  logic [TIMER_W-1:0]   timer_cnt;

  irrigation_tick_timer #(.W(TIMER_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clr),
    .tick  (timer_en),
    .count (timer_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= MODE_SPRINKLER;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      IDLE: begin
        if (level <= LEVEL_LOW) begin
          state_nxt = FILL;
          timer_clr = 1'b1;
        end else if (soil_dry) begin
          state_nxt = IRRIGATE;
          mode_nxt  = mode_drip;
`ifdef IRRIGATION_MIN_ON_EN
          timer_clr = 1'b1;
`endif
        end
      end
      FILL: begin
        timer_en = tick;
        // Reaching the high mark beats a timeout landing in the same cycle.
        if (level >= LEVEL_HIGH) begin
          state_nxt = IDLE;
        end else if (tick && (timer_cnt == TIMER_W'(FILL_TIMEOUT))) begin
          state_nxt = FAULT;
        end
      end
      IRRIGATE: begin
`ifdef IRRIGATION_MIN_ON_EN
        timer_en = tick;
`endif
        if (level <= LEVEL_LOW) begin
          state_nxt = FILL;
          timer_clr = 1'b1;
`ifdef IRRIGATION_MIN_ON_EN
        end else if (!soil_dry && (timer_cnt >= TIMER_W'(MIN_ON))) begin
`else
        end else if (!soil_dry) begin
`endif
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        if (fault_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend on registers only, so reset drops the actuators asynchronously.
  assign valve_in  = (state == FILL);
  assign sprinkler = (state == IRRIGATE) && (mode_q == MODE_SPRINKLER);
  assign dripper   = (state == IRRIGATE) && (mode_q == MODE_DRIP);
  assign alarm     = (state == FAULT);
  assign state_out = state;

endmodule

// File: tb/tb_irrigation_actuator_fsm.sv
// Scoreboard bench for irrigation_actuator_fsm built with FILL_TIMEOUT=3.
// Expected output vector is {valve_in, sprinkler, dripper, alarm, state_out[1:0]}.
module tb_irrigation_actuator_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] level = 3'd4;
  logic       soil_dry = 1'b0;
  logic       mode_drip = 1'b0;
  logic       tick = 1'b0;
  logic       fault_ack = 1'b0;
  logic       valve_in, sprinkler, dripper, alarm;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] v;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [5:0] E_IDLE  = 6'b0000_00;
  localparam logic [5:0] E_FILL  = 6'b1000_01;
  localparam logic [5:0] E_SPRK  = 6'b0100_10;
  localparam logic [5:0] E_DRIP  = 6'b0010_10;
  localparam logic [5:0] E_FAULT = 6'b0001_11;

  irrigation_actuator_fsm #(.FILL_TIMEOUT(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .level     (level),
    .soil_dry  (soil_dry),
    .mode_drip (mode_drip),
    .tick      (tick),
    .fault_ack (fault_ack),
    .valve_in  (valve_in),
    .sprinkler (sprinkler),
    .dripper   (dripper),
    .alarm     (alarm),
    .state_out (state_out)
  );

  always #5 clock = ~clock;

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {valve_in, sprinkler, dripper, alarm, state_out};
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b", e.name, act, e.v);
        end
      end
    end
  end

  task automatic step(input logic [2:0] lv, input logic dry, input logic md,
                      input logic tk, input logic ack, input logic [5:0] ev,
                      input string nm);
    exp_t e;
    @(negedge clock);
    level = lv; soil_dry = dry; mode_drip = md; tick = tk; fault_ack = ack;
    e.v = ev; e.name = nm;
    sb_q.push_back(e);
    @(posedge clock);
  endtask

  task automatic direct_check(input logic [7:0] act, input logic [7:0] req, input string nm);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3'd4, 0, 0, 0, 0, E_IDLE, "reset_state0");
    step(3'd0, 1, 1, 1, 0, E_IDLE, "reset_state1");
    @(negedge clock);
    reset = 1'b0;

    // Refill between thresholds
    step(3'd1, 0, 0, 0, 0, E_FILL, "refill_enter");
    step(3'd5, 0, 0, 0, 0, E_FILL, "refill_below_high");
    step(3'd6, 0, 0, 0, 0, E_IDLE, "refill_done");

    // Drip irrigation; mode change ignored while irrigating
    step(3'd4, 1, 1, 0, 0, E_DRIP, "irr_drip");
    step(3'd4, 1, 0, 0, 0, E_DRIP, "mode_ignored");
`ifdef IRRIGATION_MIN_ON_EN
    step(3'd4, 0, 0, 1, 0, E_DRIP, "min_on_hold");
    for (int i = 1; i < 10; i++) step(3'd4, 0, 0, 1, 0, E_DRIP, "min_on_count");
    step(3'd4, 0, 0, 0, 0, E_IDLE, "min_on_exit");
`else
    step(3'd4, 0, 0, 0, 0, E_IDLE, "dry_exit");
`endif

    // Sprinkler, then low level overrides irrigation
    step(3'd4, 1, 0, 0, 0, E_SPRK, "irr_sprk");
    step(3'd1, 1, 0, 0, 0, E_FILL, "low_override");

    // Fill timeout: tick counted only when high
    step(3'd0, 1, 0, 1, 0, E_FILL, "fill_t1");
    step(3'd0, 1, 0, 0, 0, E_FILL, "fill_notick");
    step(3'd0, 1, 0, 1, 0, E_FILL, "fill_t2");
    step(3'd0, 1, 0, 1, 0, E_FILL, "fill_t3");
    step(3'd0, 1, 0, 1, 0, E_FAULT, "fill_timeout");
    step(3'd0, 1, 1, 1, 0, E_FAULT, "fault_hold");
    step(3'd0, 0, 0, 0, 1, E_IDLE, "fault_ack");
    step(3'd0, 0, 0, 0, 0, E_FILL, "refill_after_ack");

    // Level reaching high beats a simultaneous timeout
    step(3'd0, 0, 0, 1, 0, E_FILL, "prio_t1");
    step(3'd0, 0, 0, 1, 0, E_FILL, "prio_t2");
    step(3'd0, 0, 0, 1, 0, E_FILL, "prio_t3");
    step(3'd6, 0, 0, 1, 0, E_IDLE, "level_wins");

    // Asynchronous reset in the middle of FILL
    step(3'd0, 0, 0, 1, 0, E_FILL, "pre_reset_fill");
    step(3'd0, 0, 0, 1, 0, E_FILL, "pre_reset_tick");
    #2;
    reset = 1'b1;
    #1;
    direct_check({7'd0, valve_in}, 8'd0, "async_reset_valve");
    direct_check({6'd0, state_out}, 8'd0, "async_reset_state");
    direct_check(dut.timer_cnt, 8'd0, "async_reset_timer");
    level = 3'd4; tick = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(3'd4, 0, 0, 0, 0, E_IDLE, "post_reset_idle");
    direct_check(dut.timer_cnt, 8'd0, "post_reset_timer");

    @(posedge clock);
    #3;
    direct_check(8'(sb_q.size()), 8'd0, "scoreboard_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
